q2_bus_mem: RTL
===============

# q2_bus_mem

Synthesizable memory and console responder for the q2 CPU bus. It answers the CPU's `rdm`/`wrm` strobes on `abus`/`dbus` with a 4096×12 RAM, and maps a small I/O window at the top of memory. Writes to 0xFFF are buffered in an output FIFO toward a console transmitter. Console input is presented at 0xFFD, with status at 0xFFE. It replaces the behavioural RAM model for FPGA builds and sits directly on the q2 core's bus pins.

## Interface
Parameters:
- `OUT_DEPTH`, 4: output FIFO depth; power of two, ≥2.

Ports:
- `clk`  in  1: clock shared with q2 core.
- `rst`  in  1: synchronous, active-high reset.
- `abus`  in  12: address from CPU.
- `dbus`  inout  12: data bus. Driven by this block only while `rdm`=1, otherwise high-Z.
- `rdm`  in  1: CPU read strobe.
- `wrm`  in  1: CPU write strobe.
- `out_data`  out  12: head of output FIFO.
- `out_valid`  out  1: FIFO non-empty.
- `out_ready`  in  1: console accepts head; pop when `out_valid & out_ready`.
- `in_data`  in  12: console input word.
- `in_valid`  in  1: console offers `in_data`.
- `in_ready`  out  1: input holding register empty.

## Operation
- **RAM.** 4096×12 with asynchronous read: `dbus = ram[abus]` while `rdm`=1.
- **Write strobe.** `wrm_q` is a registered copy of `wrm`; its reset value is 1, so a `wrm` held high through reset causes no write. A write commits at the posedge where `wrm`=1 and `wrm_q`=0, storing `dbus` to `ram[abus]`. A held `wrm` produces exactly one write.
- **Read strobe.** `rdm_q` is a registered copy of `rdm` (reset value 0). `rd_addr` latches `abus` every cycle that `rdm`=1.
- **Address 0xFFF.**
  - Write: stores to RAM and pushes `dbus` into the FIFO.
  - Read: returns the RAM contents (the last value written).
  - Push rule: accepted if the FIFO is not full, or if a pop occurs in the same cycle. Otherwise the word is dropped and the sticky `ovf` flag is set.
- **Address 0xFFE, read-only status.** Returns `{9'b0, ovf, in_avail, out_full}`. Writes go to RAM only.
- **Address 0xFFD, read.** Returns `in_hold`.
  - At the falling edge of the read (`rdm_q`=1, `rdm`=0, `rd_addr`=0xFFD), `in_avail` is cleared.
  - Writes go to RAM only.
- **Input path.** `in_ready = ~in_avail`. On `in_valid & in_ready`: `in_hold <= in_data` and `in_avail <= 1`. A capture and a clear can never coincide, because `in_ready` is 0 while `in_avail` is set.
- **FIFO.** Read/write pointers are `$clog2(OUT_DEPTH)+1` bits and wrap modulo 2·`OUT_DEPTH`.
  - `out_full` = pointers equal apart from their MSB.
  - `out_valid` = pointers unequal.
  - `out_data` = `mem[rptr]`, combinational from registers.
- **Reset values.** FIFO empty (`out_valid`=0, `out_data` = don't-care), `ovf`=0, `in_avail`=0 (`in_ready`=1), `in_hold`=0, `wrm_q`=1, `rdm_q`=0, `rd_addr`=0. RAM contents are not reset.

## Timing
- Read latency is zero cycles: `dbus` is valid combinationally while `rdm` and `abus` are stable.
- A write is visible to a read starting at the cycle after the committing posedge.
- A FIFO push at posedge N makes `out_valid`=1 after N. The earliest pop is at posedge N+1.
- An input capture at posedge N makes `in_ready`=0 after N. A status read returns bit1=1 from the cycle after N.
- If reset is asserted mid-transfer, any FIFO contents and pending input are lost. A write whose edge coincides with `rst` is suppressed.

## Configuration
- **`Q2_BUS_MEM_IO_EN` defined:** I/O window behaves as described above.
- **Undefined:**
  - 0xFFD–0xFFF are plain RAM and no FIFO is instantiated.
  - `out_valid`=0, `out_data`=0, `in_ready`=0.
  - `out_ready`, `in_data` and `in_valid` are ignored.

## Test plan
- **RAM round trip and single write.** Write 0x5A3 to 0x123 with `wrm` held high for 3 cycles, then read 0x123. Required: `dbus`=0x5A3, exactly one commit, and `dbus` is Z when `rdm`=0.
- **FIFO order.** With `out_ready`=0, write 0x001, 0x002, 0x003 to 0xFFF, then raise `out_ready`. Required: 0x001, 0x002, 0x003 are popped in order, then `out_valid`=0.
- **Overflow.** With `OUT_DEPTH`=4 and `out_ready`=0, write 5 words to 0xFFF. Required: the 5th word is dropped and a status read returns 0x005 (`ovf`, `out_full`). Then raise `out_ready` while writing a 6th word in the pop cycle. Required: the 6th word is accepted.
- **Input.** Drive `in_data`=0x7C1 with `in_valid`=1.
  - Required: `in_ready` falls the next cycle and a status read returns 0x002.
  - Then read 0xFFD. Required: returns 0x7C1, and after `rdm` falls `in_ready`=1.
- **Reset mid-operation.** Leave 2 words in the FIFO, hold input pending, keep `wrm` high, then pulse `rst`. Required: `out_valid`=0, `in_ready`=1, status reads 0x000, and no write occurs while `wrm` stays high.
- **Macro off.** Build without `Q2_BUS_MEM_IO_EN` and write 0x0AB to 0xFFF. Required: `out_valid` stays 0 and a read of 0xFFF returns 0x0AB.

Source files
------------

// File: rtl/q2_bus_mem_if.sv
// q2_bus_mem_if: console-side handshake bundle for q2_bus_mem.
//
// Both channels use valid/ready: a word moves on a rising clock edge where
// valid and ready are both 1. The producer holds its data stable while
// valid is 1 and ready is 0.
//
//   out_data  [11:0] head of the memory block's output FIFO
//   out_valid        output FIFO non-empty
//   out_ready        console accepts the head word
//   in_data   [11:0] console input word
//   in_valid         console offers in_data
//   in_ready         input holding register empty
//
// Modports:
//   slave  - seen by q2_bus_mem (drives out_*, in_ready)
//   master - seen by the console side (drives out_ready, in_data, in_valid)
interface q2_bus_mem_if;
  logic [11:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] in_data;
  logic        in_valid;
  logic        in_ready;

  modport slave (
    output out_data, out_valid, in_ready,
    input  out_ready, in_data, in_valid
  );

  modport master (
    input  out_data, out_valid, in_ready,
    output out_ready, in_data, in_valid
  );
endinterface

// File: rtl/q2_bus_mem.sv
// q2_bus_mem: 4096x12 RAM and console responder for the q2 CPU bus.
//
// The CPU reads with rdm (combinational, zero-latency data on dbus) and
// writes with wrm (one commit on the rising edge of wrm, however long it is
// held). With Q2_BUS_MEM_IO_EN defined, the top of memory is an I/O window:
//   0xFFF write : stored to RAM and pushed into the output FIFO
//   0xFFF read  : RAM contents (last value written)
//   0xFFE read  : status {9'b0, ovf, in_avail, out_full}
//   0xFFD read  : in_hold; in_avail clears when that read ends
// Without the macro, 0xFFD-0xFFF are plain RAM, no FIFO exists, and the
// console outputs are tied to 0.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   abus   [11:0]   CPU address
//   dbus   [11:0]   bidirectional data, driven here only while rdm=1
//   rdm, wrm        CPU read / write strobes
//   con             console handshakes (q2_bus_mem_if.slave)
//
// Parameter OUT_DEPTH: output FIFO depth, power of two, >= 2.
module q2_bus_mem #(
  parameter int OUT_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] abus,
  inout  wire  [11:0] dbus,
  input  logic        rdm,
  input  logic        wrm,
  q2_bus_mem_if.slave con
);

  localparam logic [11:0] ADDR_IN   = 12'hFFD;
  localparam logic [11:0] ADDR_STAT = 12'hFFE;
  localparam logic [11:0] ADDR_OUT  = 12'hFFF;

  logic [11:0] ram_q [4096];

  logic        wrm_q, wrm_d;
  logic        rdm_q, rdm_d;
  logic [11:0] rd_addr_q, rd_addr_d;
  logic        wr_commit;
  logic [11:0] rd_data;

  // wrm_q resets to 1 so a strobe already high when reset releases is not
  // mistaken for a new rising edge. Gating with rst drops a write whose
  // edge coincides with reset.
  assign wr_commit = wrm & ~wrm_q & ~rst;

  always_comb begin
    wrm_d     = wrm;
    rdm_d     = rdm;
    rd_addr_d = rdm ? abus : rd_addr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrm_q     <= 1'b1;
      rdm_q     <= 1'b0;
      rd_addr_q <= 12'h000;
    end else begin
      wrm_q     <= wrm_d;
      rdm_q     <= rdm_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_commit) ram_q[abus] <= dbus;
  end

`ifdef Q2_BUS_MEM_IO_EN
  localparam int PW = $clog2(OUT_DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinct.
  logic [PW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [11:0]  fifo_q [OUT_DEPTH];
  logic         ovf_q, ovf_d;
  logic         in_avail_q, in_avail_d;
  logic [11:0]  in_hold_q, in_hold_d;
  logic         out_full, pop, push_req, push_ok, capture, rd_fall;

  always_comb begin
    out_full = (wptr_q[PW] != rptr_q[PW]) &&
               (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    pop      = (wptr_q != rptr_q) & con.out_ready;
    push_req = wr_commit & (abus == ADDR_OUT);
    // A pop in the same edge frees the slot the push needs.
    push_ok  = push_req & (~out_full | pop);
    capture  = con.in_valid & ~in_avail_q;
    // The 0xFFD read is consumed when it ends, not when it starts, so the
    // CPU sees stable data for the whole strobe.
    rd_fall  = rdm_q & ~rdm & (rd_addr_q == ADDR_IN);

    wptr_d     = push_ok ? wptr_q + {{PW{1'b0}}, 1'b1} : wptr_q;
    rptr_d     = pop     ? rptr_q + {{PW{1'b0}}, 1'b1} : rptr_q;
    ovf_d      = ovf_q | (push_req & ~push_ok);
    in_hold_d  = capture ? con.in_data : in_hold_q;
    in_avail_d = in_avail_q;
    if (capture)      in_avail_d = 1'b1;
    else if (rd_fall) in_avail_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      ovf_q      <= 1'b0;
      in_avail_q <= 1'b0;
      in_hold_q  <= 12'h000;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      ovf_q      <= ovf_d;
      in_avail_q <= in_avail_d;
      in_hold_q  <= in_hold_d;
    end
  end

  // FIFO storage needs no reset; only the pointers define its contents.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wptr_q[PW-1:0]] <= dbus;
  end

  assign con.out_data  = fifo_q[rptr_q[PW-1:0]];
  assign con.out_valid = (wptr_q != rptr_q);
  assign con.in_ready  = ~in_avail_q;

  always_comb begin
    rd_data = ram_q[abus];
    if (abus == ADDR_STAT)    rd_data = {9'b0, ovf_q, in_avail_q, out_full};
    else if (abus == ADDR_IN) rd_data = in_hold_q;
  end
`else
  logic unused_io;

  assign con.out_data  = 12'h000;
  assign con.out_valid = 1'b0;
  assign con.in_ready  = 1'b0;
  assign unused_io     = ^{con.out_ready, con.in_valid, con.in_data,
                           rdm_q, rd_addr_q, ADDR_IN, ADDR_STAT, ADDR_OUT};

  always_comb begin
    rd_data = ram_q[abus];
  end
`endif

  assign dbus = rdm ? rd_data : 12'bz;

endmodule
